alu_issue_queue: RTL and testbench

// - Upstream command stage for the ALU DUT (ALU_DESIGN). It buffers fully formed ALU commands from the

---
 rtl/alu_issue_queue.sv | 143 ++++++++++++++
 tb/tb_alu_issue_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Command FIFO in front of the ALU: issues one command at a time, paces issue by the
// command's result latency and pulses done with a sequence tag when the result is due.
module alu_issue_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LAT     = 1,
  parameter int LAT_MUL = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_opa,
  input  logic [WIDTH-1:0]           s_opb,
  input  logic [3:0]                 s_cmd,
  input  logic                       s_mode,
  input  logic                       s_cin,
  input  logic [1:0]                 s_inp_valid,
  output logic [WIDTH-1:0]           OPA,
  output logic [WIDTH-1:0]           OPB,
  output logic [3:0]                 CMD,
  output logic                       MODE,
  output logic                       CIN,
  output logic [1:0]                 INP_VALID,
  output logic                       CE,
  output logic                       done,
  output logic [3:0]                 done_tag,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 fsm_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = 2 * WIDTH + 8;
  localparam int LMAX = (LAT_MUL > LAT) ? LAT_MUL : LAT;
  localparam int CW   = $clog2(LMAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Handshake: a command is taken at a rising edge when s_valid && s_ready;
  // s_ready depends only on occupancy (and reset), never on a same-cycle pop.
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [CW-1:0]    wcnt;
  logic [3:0]       tag_cnt;
  logic [3:0]       issue_tag;
  logic [1:0]       iv_q;
  logic             push;
  logic             start;
  logic             wait_last;
  logic             is_mul;
  logic [WIDTH-1:0] h_opa;
  logic [WIDTH-1:0] h_opb;
  logic [3:0]       h_cmd;
  logic             h_mode;
  logic             h_cin;
  logic [1:0]       h_iv;

  assign {h_opa, h_opb, h_cmd, h_mode, h_cin, h_iv} = mem[rd_ptr];

  assign s_ready   = RST && (level < LW'(DEPTH));
  assign push      = s_valid && s_ready && !flush;
  assign wait_last = (state == WAIT) && (wcnt == CW'(1));
  // A new command launches from IDLE, or on the edge that ends the previous wait.
  assign start     = !flush && (level != '0) && ((state == IDLE) || wait_last);
  assign is_mul    = MODE && ((CMD == 4'd9) || (CMD == 4'd10));

  assign CE        = (state != IDLE);
  assign INP_VALID = (state == ISSUE) ? iv_q : 2'b00;
  assign fsm_state = state;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {s_opa, s_opb, s_cmd, s_mode, s_cin, s_inp_valid};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      wcnt      <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      issue_tag <= '0;
      done      <= 1'b0;
      done_tag  <= '0;
      OPA       <= '0;
      OPB       <= '0;
      CMD       <= '0;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      iv_q      <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        state  <= IDLE;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (start) rd_ptr <= rd_ptr + 1'b1;
        level <= level + LW'(push) - LW'(start);

        case (state)
          IDLE: begin
            if (start) state <= ISSUE;
          end
          ISSUE: begin
            state <= WAIT;
            wcnt  <= is_mul ? CW'(LAT_MUL) : CW'(LAT);
          end
          WAIT: begin
            wcnt <= wcnt - 1'b1;
            if (wait_last) begin
              done     <= 1'b1;
              done_tag <= issue_tag;
              state    <= start ? ISSUE : IDLE;
            end
          end
          default: state <= IDLE;
        endcase

        if (start) begin
          OPA       <= h_opa;
          OPB       <= h_opb;
          CMD       <= h_cmd;
          MODE      <= h_mode;
          CIN       <= h_cin;
          iv_q      <= h_iv;
          issue_tag <= tag_cnt;
          tag_cnt   <= tag_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: timestamp-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_alu_issue_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic [1:0] iv;
  } cmd_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_opa = '0;
  logic [WIDTH-1:0] s_opb = '0;
  logic [3:0]       s_cmd = '0;
  logic             s_mode = 1'b0;
  logic             s_cin = 1'b0;
  logic [1:0]       s_inp_valid = '0;
  logic             s_ready;
  logic [WIDTH-1:0] OPA;
  logic [WIDTH-1:0] OPB;
  logic [3:0]       CMD;
  logic             MODE;
  logic             CIN;
  logic [1:0]       INP_VALID;
  logic             CE;
  logic             done;
  logic [3:0]       done_tag;
  logic [2:0]       level;
  logic [1:0]       fsm_state;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(1), .LAT_MUL(2)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_opa(s_opa), .s_opb(s_opb), .s_cmd(s_cmd), .s_mode(s_mode), .s_cin(s_cin),
    .s_inp_valid(s_inp_valid), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
    .INP_VALID(INP_VALID), .CE(CE), .done(done), .done_tag(done_tag), .level(level),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a command queue plus the issue/done timestamps of the command in flight.
  cmd_t       mq[$];
  int         cyc = 0;
  bit         inflight = 1'b0;
  int         issue_cyc = -10;
  int         done_cyc = 0;
  logic [3:0] tag_ctr = '0;
  logic [3:0] inflight_tag = '0;
  logic [3:0] e_done_tag = '0;
  bit         e_done = 1'b0;
  cmd_t       cur = '0;

  function automatic int lat_of(input cmd_t c);
    return (c.mode && (c.cmd == 4'd9 || c.cmd == 4'd10)) ? 2 : 1;
  endfunction

  always @(posedge CLK) begin : model
    cmd_t incoming;
    bit   acc;
    incoming = {s_opa, s_opb, s_cmd, s_mode, s_cin, s_inp_valid};
    acc = s_valid && (mq.size() < DEPTH);
    cyc++;
    e_done = 1'b0;
    if (!RST) begin
      mq.delete();
      inflight   = 1'b0;
      tag_ctr    = '0;
      e_done_tag = '0;
      cur        = '0;
      issue_cyc  = -10;
    end else if (flush) begin
      mq.delete();
      inflight = 1'b0;
    end else begin
      if (inflight && done_cyc == cyc) begin
        e_done     = 1'b1;
        e_done_tag = inflight_tag;
        inflight   = 1'b0;
      end
      if (!inflight && mq.size() > 0) begin
        cur          = mq.pop_front();
        inflight     = 1'b1;
        issue_cyc    = cyc;
        inflight_tag = tag_ctr;
        tag_ctr      = tag_ctr + 4'd1;
        done_cyc     = cyc + lat_of(cur) + 1;
      end
      if (acc) mq.push_back(incoming);
    end
  end

  // Scoreboard / compare process, plus observation logs for the directed checks
  logic [3:0] seen_tags[$];
  int         issue_cycles[$];
  int         done_cycles[$];
  int         max_level = 0;

  always @(negedge CLK) begin
    if (cyc > 0) begin
      chk("s_ready", 32'(s_ready), 32'(RST && (mq.size() < DEPTH)));
      chk("level", 32'(level), 32'(mq.size()));
      chk("CE", 32'(CE), 32'(inflight));
      chk("INP_VALID", 32'(INP_VALID), 32'((inflight && issue_cyc == cyc) ? cur.iv : 2'b00));
      chk("done", 32'(done), 32'(e_done));
      chk("done_tag", 32'(done_tag), 32'(e_done_tag));
      chk("OPA", 32'(OPA), 32'(cur.opa));
      chk("OPB", 32'(OPB), 32'(cur.opb));
      chk("CMD_MODE_CIN", 32'({CMD, MODE, CIN}), 32'({cur.cmd, cur.mode, cur.cin}));
      if (done) begin
        seen_tags.push_back(done_tag);
        done_cycles.push_back(cyc);
      end
      if (INP_VALID != 2'b00) issue_cycles.push_back(cyc);
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_cmd(input cmd_t c);
    s_valid     = 1'b1;
    s_opa       = c.opa;
    s_opb       = c.opb;
    s_cmd       = c.cmd;
    s_mode      = c.mode;
    s_cin       = c.cin;
    s_inp_valid = c.iv;
  endtask

  task automatic push_one(input cmd_t c);
    drive_cmd(c);
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    flush = 1'b0;
    s_valid = 1'b0;
    step();
    step();
    @(negedge CLK);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_CE", 32'(CE), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_OPA", 32'(OPA), 32'd0);
    #1;
    RST = 1'b1;
    seen_tags.delete();
    issue_cycles.delete();
    done_cycles.delete();
    max_level = 0;
  endtask

  cmd_t c_add5;
  cmd_t c_add;
  cmd_t c_mul;

  initial begin
    c_add5 = '{opa: 8'h05, opb: 8'h03, cmd: 4'd0, mode: 1'b1, cin: 1'b0, iv: 2'b11};
    c_add  = '{opa: 8'h11, opb: 8'h22, cmd: 4'd0, mode: 1'b1, cin: 1'b0, iv: 2'b11};
    c_mul  = '{opa: 8'h07, opb: 8'h06, cmd: 4'd9, mode: 1'b1, cin: 1'b0, iv: 2'b11};

    // Single add: issue one cycle after push, done two cycles after issue
    do_reset();
    push_one(c_add5);
    wait_neg(1);
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_CE_before_issue", 32'(CE), 32'd0);
    wait_neg(1);
    chk("t1_OPA", 32'(OPA), 32'h05);
    chk("t1_OPB", 32'(OPB), 32'h03);
    chk("t1_CE_issue", 32'(CE), 32'd1);
    chk("t1_INP_VALID", 32'(INP_VALID), 32'd3);
    wait_neg(1);
    chk("t1_done_early", 32'(done), 32'd0);
    wait_neg(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_tag", 32'(done_tag), 32'd0);

    // Three back-to-back adds
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cmd(c_add);
      step();
    end
    s_valid = 1'b0;
    repeat (10) step();
    chk("t2_ndone", 32'(seen_tags.size()), 32'd3);
    if (seen_tags.size() == 3) begin
      chk("t2_tag0", 32'(seen_tags[0]), 32'd0);
      chk("t2_tag1", 32'(seen_tags[1]), 32'd1);
      chk("t2_tag2", 32'(seen_tags[2]), 32'd2);
    end
    chk("t2_nissue", 32'(issue_cycles.size()), 32'd3);
    if (issue_cycles.size() == 3) begin
      chk("t2_gap01", 32'(issue_cycles[1] - issue_cycles[0]), 32'd2);
      chk("t2_gap12", 32'(issue_cycles[2] - issue_cycles[1]), 32'd2);
    end
    chk("t2_level_drained", 32'(level), 32'd0);

    // Multiply followed by an add
    do_reset();
    push_one(c_mul);
    push_one(c_add);
    repeat (10) step();
    chk("t3_nissue", 32'(issue_cycles.size()), 32'd2);
    chk("t3_ndone", 32'(done_cycles.size()), 32'd2);
    if (issue_cycles.size() == 2 && done_cycles.size() == 2) begin
      chk("t3_mul_done_lat", 32'(done_cycles[0] - issue_cycles[0]), 32'd3);
      chk("t3_add_issue_gap", 32'(issue_cycles[1] - issue_cycles[0]), 32'd3);
      chk("t3_add_done_lat", 32'(done_cycles[1] - issue_cycles[1]), 32'd2);
      chk("t3_tag0", 32'(seen_tags[0]), 32'd0);
      chk("t3_tag1", 32'(seen_tags[1]), 32'd1);
    end

    // Fill the queue while the ALU is busy
    do_reset();
    push_one(c_mul);
    for (int i = 0; i < 8; i++) begin
      drive_cmd(c_add);
      step();
    end
    s_valid = 1'b0;
    chk("t4_max_level", 32'(max_level), 32'd4);
    repeat (20) step();
    chk("t4_level_drained", 32'(level), 32'd0);

    // Flush during WAIT with two commands queued
    do_reset();
    push_one(c_mul);
    push_one(c_add);
    push_one(c_add);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_neg(1);
    chk("t5_level_flushed", 32'(level), 32'd0);
    chk("t5_CE_flushed", 32'(CE), 32'd0);
    wait_neg(6);
    chk("t5_no_done", 32'(seen_tags.size()), 32'd0);
    step();
    push_one(c_add);
    repeat (5) step();
    chk("t5_ndone", 32'(seen_tags.size()), 32'd1);
    if (seen_tags.size() == 1) chk("t5_next_tag", 32'(seen_tags[0]), 32'd1);

    // Reset mid-WAIT, then tag wrap
    do_reset();
    push_one(c_mul);
    step();
    step();
    RST = 1'b0;
    step();
    step();
    wait_neg(1);
    chk("t6_CE_reset", 32'(CE), 32'd0);
    chk("t6_OPA_reset", 32'(OPA), 32'd0);
    chk("t6_CMD_reset", 32'(CMD), 32'd0);
    chk("t6_no_done", 32'(seen_tags.size()), 32'd0);
    #1;
    RST = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      push_one(c_add);
      step();
    end
    repeat (6) step();
    chk("t6_ndone", 32'(seen_tags.size()), 32'd17);
    if (seen_tags.size() == 17) begin
      chk("t6_first_tag", 32'(seen_tags[0]), 32'd0);
      chk("t6_tag15", 32'(seen_tags[15]), 32'd15);
      chk("t6_tag_wrap", 32'(seen_tags[16]), 32'd0);
    end

    // Randomized traffic with occasional flush and reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cmd_t r;
      r.opa  = 8'($urandom_range(0, 255));
      r.opb  = 8'($urandom_range(0, 255));
      r.cmd  = 4'($urandom_range(0, 15));
      r.mode = 1'($urandom_range(0, 1));
      r.cin  = 1'($urandom_range(0, 1));
      r.iv   = 2'($urandom_range(0, 3));
      drive_cmd(r);
      s_valid = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      RST     = ($urandom_range(0, 149) != 0);
      step();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    RST     = 1'b1;
    repeat (20) step();

    $display("final fsm_state=%0d", fsm_state);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
